// File: rtl/timer_sched_pkg.sv
// Shared types and register map for the timer slot scheduler.
// Holds the FSM encoding, timer slave addresses and control words.
package timer_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    STOP,
    WR_PL,
    WR_PH,
    CLR,
    START,
    WAIT,
    ACK,
    AB_STOP,
    AB_CLR
  } state_t;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  localparam logic [15:0] CTRL_STOP      = 16'h0008;
  localparam logic [15:0] CTRL_START_ITO = 16'h0005;

  function automatic logic [2:0] rr_next(
    input logic [2:0] idx,
    input int         n
  );
    return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/timer_slot_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         grant_valid,
  output logic [2:0]   grant_idx
);

  int idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/timer_slot_scheduler.sv
// Shares one interval timer among NUM_REQ requesters, one
// one-shot timeout at a time, in round-robin order.
module timer_slot_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MIN_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_period,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic                  busy,
  output logic [2:0]            active_id,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic                  tmr_irq
);

  state_t               state;
  state_t               state_n;
  logic [2:0]           rr_ptr;
  logic [2:0]           id_q;
  logic [31:0]          p_q;
  logic [31:0]          pm1;
  logic [31:0]          per_sel;
  logic [NUM_REQ-1:0]   done_q;
  logic                 err_q;
  logic [NUM_REQ-1:0]   id_mask;
  logic [NUM_REQ-1:0]   gnt_mask;
  logic                 grant_valid;
  logic [2:0]           grant_idx;
  logic                 grant_ok;
  logic                 period_ok;
  logic                 abort;
  logic                 wr;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    per_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) per_sel = req_period[i*32 +: 32];
    end
  end

  assign id_mask   = NUM_REQ'(1) << id_q;
  assign gnt_mask  = NUM_REQ'(1) << grant_idx;
  assign period_ok = per_sel >= 32'(MIN_PERIOD);
  assign abort     = ~|(req_valid & id_mask);
  assign pm1       = p_q - 32'd1;

  // A reject pulses done while still in IDLE; hold off the next
  // grant for that cycle so the requester can withdraw.
  assign grant_ok = (state == IDLE) && grant_valid && ~|done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (grant_ok && period_ok) state_n = STOP;
      STOP:    state_n = abort ? AB_STOP : WR_PL;
      WR_PL:   state_n = abort ? AB_STOP : WR_PH;
      WR_PH:   state_n = abort ? AB_STOP : CLR;
      CLR:     state_n = abort ? AB_STOP : START;
      START:   state_n = abort ? AB_STOP : WAIT;
      WAIT: begin
        if (abort)        state_n = AB_STOP;
        else if (tmr_irq) state_n = ACK;
      end
      ACK:     state_n = IDLE;
      AB_STOP: state_n = AB_CLR;
      AB_CLR:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wr            = 1'b0;
    tmr_address   = ADDR_STATUS;
    tmr_writedata = 16'h0000;
    unique case (state)
      STOP, AB_STOP: begin
        wr            = 1'b1;
        tmr_address   = ADDR_CONTROL;
        tmr_writedata = CTRL_STOP;
      end
      WR_PL: begin
        wr            = 1'b1;
        tmr_address   = ADDR_PERIODL;
        tmr_writedata = pm1[15:0];
      end
      WR_PH: begin
        wr            = 1'b1;
        tmr_address   = ADDR_PERIODH;
        tmr_writedata = pm1[31:16];
      end
      CLR, ACK, AB_CLR: begin
        wr            = 1'b1;
        tmr_address   = ADDR_STATUS;
      end
      START: begin
        wr            = 1'b1;
        tmr_address   = ADDR_CONTROL;
        tmr_writedata = CTRL_START_ITO;
      end
      default: ;
    endcase
  end

  assign tmr_chipselect = wr;
  assign tmr_write_n    = ~wr;
  assign busy           = (state != IDLE);
  assign active_id      = id_q;
  assign done           = done_q;
  assign err            = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 3'd0;
      id_q   <= 3'd0;
      p_q    <= 32'd0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      if (grant_ok) begin
        id_q <= grant_idx;
        p_q  <= per_sel;
        if (!period_ok) begin
          done_q <= gnt_mask;
          err_q  <= 1'b1;
          rr_ptr <= rr_next(grant_idx, NUM_REQ);
        end
      end
      if (state == WAIT && state_n == ACK) done_q <= id_mask;
      if (state == ACK || state == AB_CLR)
        rr_ptr <= rr_next(id_q, NUM_REQ);
    end
  end

endmodule
